jk_cmd_driver: RTL and testbench

Command-driven stimulus and checking stage that sits directly upstream of the JK flip-flop. It accepts hold/reset/set/toggle commands over a valid/ready handshake and drives the flip-flop's `j`/`k` inputs for a programmable number of clock cycles. It keeps a cycle-accurate model of the expected `Q`, compares it against the flip-flop's fed-back `Q`, and flags any divergence.

---
 rtl/jk_cmd_driver.sv | 113 +++++++++++
 tb/tb_jk_cmd_driver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_driver.sv
// Command-driven J/K stimulus stage for a downstream JK flip-flop.
// Drives j/k per accepted command, models the expected Q and counts divergences from q_fb.
module jk_cmd_driver #(
    parameter int CNT_W = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             exp_q,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; the source keeps cmd_valid and its payload stable until then.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               j_q, j_d;
    logic               k_q, k_d;
    logic               exp_q_q, exp_q_d;
    logic               mismatch_q, mismatch_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               accept;
    logic               diff;

    assign cmd_ready = rst & (state_q == IDLE);
    assign busy      = (state_q == DRIVE) | (state_q == CHECK);
    assign done      = (state_q == CHECK);
    assign accept    = cmd_valid & cmd_ready;
    assign diff      = (q_fb != exp_q_q);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DRIVE;
                    op_d    = cmd_op;
                    cnt_d   = cmd_cnt;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) state_d = CHECK;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // j/k are registered so they are already valid in the cycle after the handshake edge.
        j_d = (state_d == DRIVE) & op_d[1];
        k_d = (state_d == DRIVE) & op_d[0];

        // Model advances with the same j/k the flip-flop samples on this edge.
        case ({j_q, k_q})
            2'b00:   exp_q_d = exp_q_q;
            2'b01:   exp_q_d = 1'b0;
            2'b10:   exp_q_d = 1'b1;
            default: exp_q_d = ~exp_q_q;
        endcase

        mismatch_d = mismatch_q | diff;
        err_cnt_d  = err_cnt_q;
        if (diff && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            cnt_q      <= '0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            exp_q_q    <= 1'b0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            j_q        <= j_d;
            k_q        <= k_d;
            exp_q_q    <= exp_q_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign exp_q    = exp_q_q;
    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver: a JK flip-flop closes the loop on the main instance,
// a second instance with a 2-bit error counter exercises saturation.
module tb_jk_cmd_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_cnt = 4'd0;
    logic       force_fb = 1'b0;
    logic       jk_q;
    logic       q_fb;

    logic       cmd_ready, j, k, exp_q, busy, done, mismatch;
    logic [7:0] err_cnt;

    logic       sat_fb = 1'b0;
    logic       s_ready, s_j, s_k, s_exp_q, s_busy, s_done, s_mismatch;
    logic [1:0] s_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Real JK flip-flop on the loop, reset alongside the driver.
    always @(posedge clk) begin
        if (!rst) jk_q <= 1'b0;
        else begin
            case ({j, k})
                2'b00: jk_q <= jk_q;
                2'b01: jk_q <= 1'b0;
                2'b10: jk_q <= 1'b1;
                2'b11: jk_q <= ~jk_q;
            endcase
        end
    end

    assign q_fb = force_fb ? 1'b1 : jk_q;

    jk_cmd_driver #(.CNT_W(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .j(j), .k(k), .q_fb(q_fb),
        .exp_q(exp_q), .busy(busy), .done(done), .mismatch(mismatch), .err_cnt(err_cnt)
    );

    jk_cmd_driver #(.CNT_W(4), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cmd_valid(1'b0), .cmd_ready(s_ready),
        .cmd_op(2'b00), .cmd_cnt(4'd0), .j(s_j), .k(s_k), .q_fb(sat_fb),
        .exp_q(s_exp_q), .busy(s_busy), .done(s_done), .mismatch(s_mismatch), .err_cnt(s_err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_jk(input string tag, input logic ej, input logic ek);
        chk({tag, ".j"}, 32'(j), 32'(ej));
        chk({tag, ".k"}, 32'(k), 32'(ek));
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
    endtask

    initial begin
        int busy_cycles;

        // Reset held for two edges.
        tick();
        tick();
        chk("rst.ready", 32'(cmd_ready), 0);
        chk_jk("rst", 1'b0, 1'b0);
        chk("rst.exp_q", 32'(exp_q), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);

        rst = 1'b1;
        #1;
        chk("rel.ready", 32'(cmd_ready), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("idle.ready", 32'(cmd_ready), 1);
        chk_jk("idle", 1'b0, 1'b0);
        chk("idle.exp_q", 32'(exp_q), 0);
        chk("idle.mismatch", 32'(mismatch), 0);
        chk("idle.err_cnt", 32'(err_cnt), 0);

        // Set, cnt=0: one drive cycle, then done.
        send(2'b10, 4'd0);
        tick();
        cmd_valid = 1'b0;
        chk_jk("set.e0", 1'b1, 1'b0);
        chk("set.e0.busy", 32'(busy), 1);
        chk("set.e0.ready", 32'(cmd_ready), 0);
        chk("set.e0.done", 32'(done), 0);
        tick();
        chk_jk("set.e1", 1'b0, 1'b0);
        chk("set.e1.done", 32'(done), 1);
        chk("set.e1.exp_q", 32'(exp_q), 1);
        tick();
        chk("set.e2.done", 32'(done), 0);
        chk("set.e2.ready", 32'(cmd_ready), 1);
        chk("set.e2.mismatch", 32'(mismatch), 0);

        // Reset op, cnt=0, back to Q=0.
        send(2'b01, 4'd0);
        tick();
        cmd_valid = 1'b0;
        chk_jk("clr.e0", 1'b0, 1'b1);
        tick();
        chk("clr.e1.exp_q", 32'(exp_q), 0);
        tick();

        // Toggle, cnt=2 from Q=0: exp 1,0,1, done on 4th busy cycle.
        send(2'b11, 4'd2);
        tick();
        cmd_valid = 1'b0;
        busy_cycles = 32'(busy);
        chk_jk("tog.e0", 1'b1, 1'b1);
        tick();
        busy_cycles += 32'(busy);
        chk("tog.e1.exp_q", 32'(exp_q), 1);
        chk_jk("tog.e1", 1'b1, 1'b1);
        tick();
        busy_cycles += 32'(busy);
        chk("tog.e2.exp_q", 32'(exp_q), 0);
        chk("tog.e2.done", 32'(done), 0);
        tick();
        busy_cycles += 32'(busy);
        chk("tog.e3.exp_q", 32'(exp_q), 1);
        chk("tog.e3.done", 32'(done), 1);
        chk_jk("tog.e3", 1'b0, 1'b0);
        tick();
        busy_cycles += 32'(busy);
        chk("tog.busy_cycles", 32'(busy_cycles), 4);
        chk("tog.e4.done", 32'(done), 0);
        chk("tog.e4.mismatch", 32'(mismatch), 0);

        // Back-to-back: second command held valid through the first.
        send(2'b10, 4'd1);
        tick();
        send(2'b01, 4'd1);
        chk_jk("b2b.a.e0", 1'b1, 1'b0);
        tick();
        chk_jk("b2b.a.e1", 1'b1, 1'b0);
        tick();
        chk("b2b.a.e2.done", 32'(done), 1);
        chk("b2b.a.e2.ready", 32'(cmd_ready), 0);
        chk("b2b.a.e2.exp_q", 32'(exp_q), 1);
        tick();
        chk("b2b.e3.ready", 32'(cmd_ready), 1);
        chk("b2b.e3.busy", 32'(busy), 0);
        chk_jk("b2b.e3", 1'b0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk_jk("b2b.b.e4", 1'b0, 1'b1);
        chk("b2b.b.e4.busy", 32'(busy), 1);
        tick();
        chk("b2b.b.e5.exp_q", 32'(exp_q), 0);
        tick();
        chk("b2b.b.e6.done", 32'(done), 1);
        tick();
        chk("b2b.e7.exp_q", 32'(exp_q), 0);
        chk("b2b.e7.mismatch", 32'(mismatch), 0);

        // Forced fault: q_fb=1 while exp_q=0 for three edges.
        force_fb = 1'b1;
        tick();
        chk("flt.1.err_cnt", 32'(err_cnt), 1);
        chk("flt.1.mismatch", 32'(mismatch), 1);
        tick();
        tick();
        force_fb = 1'b0;
        chk("flt.3.err_cnt", 32'(err_cnt), 3);
        tick();
        tick();
        chk("flt.after.err_cnt", 32'(err_cnt), 3);
        chk("flt.after.mismatch", 32'(mismatch), 1);

        // Reset in the 2nd cycle of toggle cnt=5.
        send(2'b11, 4'd5);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("abort.e1.exp_q", 32'(exp_q), 1);
        rst = 1'b0;
        tick();
        chk_jk("abort.e2", 1'b0, 1'b0);
        chk("abort.e2.busy", 32'(busy), 0);
        chk("abort.e2.done", 32'(done), 0);
        chk("abort.e2.exp_q", 32'(exp_q), 0);
        chk("abort.e2.mismatch", 32'(mismatch), 0);
        chk("abort.e2.err_cnt", 32'(err_cnt), 0);
        chk("abort.e2.ready", 32'(cmd_ready), 0);
        rst = 1'b1;
        tick();
        chk("abort.e3.done", 32'(done), 0);
        chk("abort.e3.ready", 32'(cmd_ready), 1);
        chk_jk("abort.e3", 1'b0, 1'b0);

        // Normal command after release: set, cnt=3 -> done after 4 drive cycles.
        send(2'b10, 4'd3);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post.drive.done", 32'(done), 0);
            chk_jk("post.drive", 1'b1, 1'b0);
        end
        tick();
        chk("post.done", 32'(done), 1);
        chk("post.exp_q", 32'(exp_q), 1);
        tick();
        chk("post.idle.mismatch", 32'(mismatch), 0);
        chk("post.idle.ready", 32'(cmd_ready), 1);

        // Saturation with ERR_W=2 under a persistent fault.
        chk("sat.pre.err_cnt", 32'(s_err_cnt), 0);
        sat_fb = 1'b1;
        tick();
        chk("sat.1.err_cnt", 32'(s_err_cnt), 1);
        tick();
        tick();
        chk("sat.3.err_cnt", 32'(s_err_cnt), 3);
        tick();
        tick();
        chk("sat.5.err_cnt", 32'(s_err_cnt), 3);
        chk("sat.5.mismatch", 32'(s_mismatch), 1);
        sat_fb = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
